// File: rtl/magnitude_comparator_seq.sv
// magnitude_comparator_seq
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands one DIGIT-bit
// slice per clock, most significant slice first, and stops at the first slice
// that differs. Two's-complement order is obtained by flipping the operand MSBs
// at capture (offset-binary), after which every slice compare is unsigned.
// Handshake: start is taken only while idle; busy covers the walk; done pulses
// for one cycle with the one-hot result R = {G,E,L}, which then holds until the
// next accepted start clears it.
module magnitude_comparator_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [2:0]       R
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    localparam logic [2:0] R_GT   = 3'b100;
    localparam logic [2:0] R_EQ   = 3'b010;
    localparam logic [2:0] R_LT   = 3'b001;
    localparam logic [2:0] R_NONE = 3'b000;

    // The slice walk only makes sense when the operand splits into whole slices.
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_params
        $error("magnitude_comparator_seq: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_r;

    logic [WIDTH-1:0] w_msb_flip;
    logic [DIGIT-1:0] w_slice_a;
    logic [DIGIT-1:0] w_slice_b;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the slice datapath needs no mode awareness.
    assign w_msb_flip = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    // The slice under test is always the top DIGIT bits of the shift registers.
    assign w_slice_a = r_a[WIDTH-1 -: DIGIT];
    assign w_slice_b = r_b[WIDTH-1 -: DIGIT];

    // Single-process FSM: operand capture, slice-by-slice compare, registered handshake outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_r     <= R_NONE;
        end else begin
            // NOTE: non-blocking assignments throughout, so every compare below sees
            // the register values from before this edge; done defaults low each cycle
            // and is raised only on the finishing edge, which makes it a one-cycle pulse.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A ^ w_msb_flip;
                        r_b     <= B ^ w_msb_flip;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_r     <= R_NONE;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_slice_a != w_slice_b) begin
                        r_r     <= (w_slice_a > w_slice_b) ? R_GT : R_LT;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_k == K_LAST) begin
                        r_r     <= R_EQ;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_a <= r_a << DIGIT;
                        r_b <= r_b << DIGIT;
                        r_k <= r_k + KW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign R    = r_r;

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// tb_magnitude_comparator_seq
// Three instances share one clock and reset: 16/4 (main), 8/1 (bit-serial) and
// 4/4 (single slice). Results and done latency are predicted from the operand
// values with plain integer arithmetic.
module tb_magnitude_comparator_seq;

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    logic        st16, sm16, st8, sm8, st4, sm4;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;

    logic        busy_o [3];
    logic        done_o [3];
    logic [2:0]  r_o    [3];

    int n_cmp = 0;
    int n_err = 0;

    magnitude_comparator_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .nrst(nrst), .start(st16), .signed_mode(sm16), .A(a16), .B(b16),
        .busy(busy_o[0]), .done(done_o[0]), .R(r_o[0])
    );

    magnitude_comparator_seq #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .nrst(nrst), .start(st8), .signed_mode(sm8), .A(a8), .B(b8),
        .busy(busy_o[1]), .done(done_o[1]), .R(r_o[1])
    );

    magnitude_comparator_seq #(.WIDTH(4), .DIGIT(4)) u_dut4 (
        .clk(clk), .nrst(nrst), .start(st4), .signed_mode(sm4), .A(a4), .B(b4),
        .busy(busy_o[2]), .done(done_o[2]), .R(r_o[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int idx);
        return (idx == 0) ? 16 : (idx == 1) ? 8 : 4;
    endfunction

    function automatic int digit_of(input int idx);
        return (idx == 1) ? 1 : 4;
    endfunction

    // Reference: order from integer values, latency from the first differing slice.
    function automatic void model(input int idx, input logic [15:0] av, input logic [15:0] bv,
                                  input logic smv, output logic [2:0] r, output int lat);
        int     w;
        int     dg;
        int     nd;
        longint one;
        longint ua;
        longint ub;
        longint va;
        longint vb;
        w   = width_of(idx);
        dg  = digit_of(idx);
        nd  = w / dg;
        one = 1;
        ua  = longint'(av) & ((one << w) - 1);
        ub  = longint'(bv) & ((one << w) - 1);
        va  = ua;
        vb  = ub;
        if (smv && va >= (one << (w - 1))) va = va - (one << w);
        if (smv && vb >= (one << (w - 1))) vb = vb - (one << w);
        r   = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
        lat = nd;
        for (int i = 0; i < nd; i++) begin
            if ((((ua ^ ub) >> (w - dg * (i + 1))) & ((one << dg) - 1)) != 0) begin
                lat = i + 1;
                break;
            end
        end
    endfunction

    task automatic drive(input int idx, input logic s, input logic [15:0] av,
                         input logic [15:0] bv, input logic smv);
        case (idx)
            0: begin st16 = s; a16 = av;      b16 = bv;      sm16 = smv; end
            1: begin st8  = s; a8  = av[7:0]; b8  = bv[7:0]; sm8  = smv; end
            default: begin st4 = s; a4 = av[3:0]; b4 = bv[3:0]; sm4 = smv; end
        endcase
    endtask

    // Pulse start for one cycle; returns at the falling edge after the accepting edge.
    task automatic launch(input int idx, input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic smv);
        @(negedge clk);
        drive(idx, 1'b1, av, bv, smv);
        @(negedge clk);
        drive(idx, 1'b0, av, bv, smv);
        check({tag, "_busy0"}, 32'(busy_o[idx]), 32'd1);
        check({tag, "_r0"},    32'(r_o[idx]),    32'd0);
        check({tag, "_done0"}, 32'(done_o[idx]), 32'd0);
    endtask

    // Count edges after the accepting edge until done; cnt starts at edges already elapsed.
    task automatic wait_done(input int idx, input string tag, input logic [2:0] exp_r,
                             input int exp_lat, input int start_cnt);
        int cnt;
        bit seen;
        cnt  = start_cnt;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (done_o[idx]) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_lat"},  32'(cnt),          32'(exp_lat));
            check({tag, "_r"},    32'(r_o[idx]),     32'(exp_r));
            check({tag, "_busy"}, 32'(busy_o[idx]),  32'd0);
        end
    endtask

    task automatic hold(input int idx, input string tag, input logic [2:0] exp_r);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done_o[idx]), 32'd0);
        check({tag, "_hold"},  32'(r_o[idx]),    32'(exp_r));
    endtask

    task automatic run_op(input int idx, input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic smv);
        logic [2:0] er;
        int         el;
        model(idx, av, bv, smv, er, el);
        launch(idx, tag, av, bv, smv);
        wait_done(idx, tag, er, el, 0);
        hold(idx, tag, er);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] corners [5];

        nrst = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0, 16'h0, 1'b0);
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy_o[i]), 32'd0);
            check("rst_done", 32'(done_o[i]), 32'd0);
            check("rst_r",    32'(r_o[i]),    32'd0);
        end
        @(negedge clk);
        nrst = 1'b1;

        // Equality walks every slice.
        run_op(0, "eq1234", 16'h1234, 16'h1234, 1'b0);

        // Early exit on the top slice, both modes.
        run_op(0, "early_u", 16'h8000, 16'h7FFF, 1'b0);
        run_op(0, "early_s", 16'h8000, 16'h7FFF, 1'b1);

        // Late difference with start held high through done for back-to-back.
        @(negedge clk);
        drive(0, 1'b1, 16'h00F1, 16'h00F2, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0);
        wait_done(0, "late", 3'b001, 4, 0);
        @(negedge clk);
        drive(0, 1'b0, 16'hFFFF, 16'hFFFE, 1'b0);
        check("b2b_busy", 32'(busy_o[0]), 32'd1);
        check("b2b_r0",   32'(r_o[0]),    32'd0);
        check("b2b_done", 32'(done_o[0]), 32'd0);
        wait_done(0, "b2b", 3'b100, 4, 0);
        hold(0, "b2b", 3'b100);

        // A second start while busy must be ignored.
        launch(0, "busyprot", 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        wait_done(0, "busyprot", 3'b010, 4, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busyprot_nodone", 32'(done_o[0]), 32'd0);
            check("busyprot_idle",   32'(busy_o[0]), 32'd0);
            check("busyprot_r",      32'(r_o[0]),    32'd2);
        end

        // Reset in the middle of an operation aborts it silently.
        launch(0, "rstmid", 16'h1111, 16'h1112, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy_o[0]), 32'd0);
        check("rstmid_r",    32'(r_o[0]),    32'd0);
        check("rstmid_done", 32'(done_o[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rstmid_hold_done", 32'(done_o[0]), 32'd0);
        end
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstmid_post_done", 32'(done_o[0]), 32'd0);
            check("rstmid_post_r",    32'(r_o[0]),    32'd0);
        end
        run_op(0, "after_rst", 16'h1111, 16'h1112, 1'b0);

        // Random 16/4 operations, biased towards shared prefixes.
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            run_op(0, "rnd16", ra, rb, 1'($urandom));
        end

        // 8/1 bit-serial: corner values, then random, both modes.
        corners[0] = 16'h00; corners[1] = 16'h01; corners[2] = 16'h7F;
        corners[3] = 16'h80; corners[4] = 16'hFF;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    run_op(1, "w8_corner", corners[i], corners[j], 1'(m));
                end
            end
            for (int n = 0; n < 300; n++) begin
                ra = 16'($urandom_range(0, 255));
                rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom_range(0, 255));
                run_op(1, "w8_rnd", ra, rb, 1'(m));
            end
        end

        // Single-slice instance, exhaustive in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    run_op(2, "w4", 16'(i), 16'(j), 1'(m));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
